store_buffer_fwd: RTL and testbench

//  Parametrised circular store buffer between the dcache M1 stage and commit. Holds speculative
//  and committed stores, forwards bytes to loads youngest-first, and coalesces same-word stores.

---
 rtl/store_buffer_fwd.sv | 149 ++++++++++++++
 tb/tb_store_buffer_fwd.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer_fwd.sv
// Circular store buffer: committed entries [head,commit) drain in order, speculative entries
// [commit,tail) die on flush; loads see youngest-first byte forwarding from every live entry.
module store_buffer_fwd #(
    parameter int SB_DEPTH = 4,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int WAY_NUM  = 2,
    parameter bit COALESCE = 1'b1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush_i,
    input  logic                            enq_valid_i,
    output logic                            enq_ready_o,
    input  logic [ADDR_W-1:0]               enq_addr_i,
    input  logic [DATA_W-1:0]               enq_data_i,
    input  logic [DATA_W/8-1:0]             enq_strb_i,
    input  logic                            enq_uncached_i,
    input  logic [WAY_NUM-1:0]              enq_hit_i,
    input  logic                            commit_i,
    output logic                            deq_valid_o,
    input  logic                            deq_ready_i,
    output logic [ADDR_W-1:0]               deq_addr_o,
    output logic [DATA_W-1:0]               deq_data_o,
    output logic [DATA_W/8-1:0]             deq_strb_o,
    output logic                            deq_uncached_o,
    output logic [WAY_NUM-1:0]              deq_hit_o,
    input  logic [ADDR_W-1:0]               ld_addr_i,
    output logic [DATA_W-1:0]               fwd_data_o,
    output logic [DATA_W/8-1:0]             fwd_mask_o,
    output logic [$clog2(SB_DEPTH+1)-1:0]   count_o,
    output logic                            empty_o
);
    localparam int IW  = $clog2(SB_DEPTH);
    localparam int PW  = IW + 1;
    localparam int SW  = DATA_W / 8;
    localparam int OFF = $clog2(SW);
    localparam int CW  = $clog2(SB_DEPTH + 1);

    logic [PW-1:0]      head_q, head_d, commit_q, commit_d, tail_q, tail_d;
    logic [SB_DEPTH-1:0] valid_q;
    logic [ADDR_W-1:0]  addr_q [SB_DEPTH];
    logic [DATA_W-1:0]  data_q [SB_DEPTH];
    logic [SW-1:0]      strb_q [SB_DEPTH];
    logic [SB_DEPTH-1:0] unc_q;
    logic [WAY_NUM-1:0] hit_q [SB_DEPTH];

    logic [IW-1:0] head_idx, tail_idx, young_idx, fwd_idx;
    logic [PW-1:0] occ, n_keep;
    logic          full, empty, coal_hit, enq_fire, deq_fire, commit_ok;
    logic          unused_ld_off;

    assign head_idx  = head_q[IW-1:0];
    assign tail_idx  = tail_q[IW-1:0];
    assign young_idx = tail_idx - IW'(1);
    assign occ       = tail_q - head_q;
    assign empty     = (head_q == tail_q);
    assign full      = (head_idx == tail_idx) && (head_q[IW] != tail_q[IW]);

    // Only the youngest entry may absorb a store, and only while it is still speculative.
    assign coal_hit = COALESCE && !empty && (commit_q != tail_q) && !unc_q[young_idx]
                      && !enq_uncached_i
                      && (addr_q[young_idx][ADDR_W-1:OFF] == enq_addr_i[ADDR_W-1:OFF]);

    assign enq_ready_o = !flush_i && (!full || coal_hit);
    assign enq_fire    = enq_valid_i && enq_ready_o;
    assign deq_valid_o = (head_q != commit_q);
    assign deq_fire    = deq_valid_o && deq_ready_i;
    assign commit_ok   = commit_i && (commit_q != tail_q);

    always_comb begin
        head_d   = head_q + PW'(deq_fire);
        commit_d = commit_q + PW'(commit_ok);
        tail_d   = tail_q;
        if (flush_i) begin
            tail_d = commit_d;
        end else if (enq_fire && !coal_hit) begin
            tail_d = tail_q + PW'(1);
        end
    end

    assign n_keep = commit_d - head_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q   <= '0;
            commit_q <= '0;
            tail_q   <= '0;
            valid_q  <= '0;
        end else begin
            head_q   <= head_d;
            commit_q <= commit_d;
            tail_q   <= tail_d;
            if (deq_fire) valid_q[head_idx] <= 1'b0;
            if (flush_i) begin
                for (int i = 0; i < SB_DEPTH; i++) begin
                    if (PW'(IW'(i) - head_idx) >= n_keep) valid_q[i] <= 1'b0;
                end
            end
            if (enq_fire && !coal_hit) valid_q[tail_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (enq_fire) begin
            if (coal_hit) begin
                for (int b = 0; b < SW; b++) begin
                    if (enq_strb_i[b]) data_q[young_idx][b*8 +: 8] <= enq_data_i[b*8 +: 8];
                end
                strb_q[young_idx] <= strb_q[young_idx] | enq_strb_i;
            end else begin
                addr_q[tail_idx] <= enq_addr_i;
                data_q[tail_idx] <= enq_data_i;
                strb_q[tail_idx] <= enq_strb_i;
                unc_q[tail_idx]  <= enq_uncached_i;
                hit_q[tail_idx]  <= enq_hit_i;
            end
        end
    end

    // Walk oldest to youngest so later matches overwrite earlier ones per byte.
    always_comb begin
        fwd_data_o = '0;
        fwd_mask_o = '0;
        fwd_idx    = '0;
        for (int k = 0; k < SB_DEPTH; k++) begin
            fwd_idx = head_idx + IW'(k);
            if (valid_q[fwd_idx] && (PW'(k) < occ)
                && (addr_q[fwd_idx][ADDR_W-1:OFF] == ld_addr_i[ADDR_W-1:OFF])) begin
                for (int b = 0; b < SW; b++) begin
                    if (strb_q[fwd_idx][b]) begin
                        fwd_data_o[b*8 +: 8] = data_q[fwd_idx][b*8 +: 8];
                        fwd_mask_o[b]        = 1'b1;
                    end
                end
            end
        end
    end

    assign unused_ld_off  = ^ld_addr_i[OFF-1:0];
    assign deq_addr_o     = addr_q[head_idx];
    assign deq_data_o     = data_q[head_idx];
    assign deq_strb_o     = strb_q[head_idx];
    assign deq_uncached_o = unc_q[head_idx];
    assign deq_hit_o      = hit_q[head_idx];
    assign count_o        = CW'(occ);
    assign empty_o        = empty;

endmodule

// File: tb/tb_store_buffer_fwd.sv
// Directed bench for store_buffer_fwd: enqueue/commit/drain, coalescing, full, flush,
// forwarding priority, uncached handling, and a queue-model run through pointer wrap.
module tb_store_buffer_fwd;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_i, enq_valid_i, enq_ready_o, enq_uncached_i, commit_i;
    logic [31:0] enq_addr_i, enq_data_i;
    logic [3:0]  enq_strb_i;
    logic [1:0]  enq_hit_i;
    logic        deq_valid_o, deq_ready_i, deq_uncached_o;
    logic [31:0] deq_addr_o, deq_data_o;
    logic [3:0]  deq_strb_o;
    logic [1:0]  deq_hit_o;
    logic [31:0] ld_addr_i, fwd_data_o;
    logic [3:0]  fwd_mask_o;
    logic [2:0]  count_o;
    logic        empty_o;

    int n_chk = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    always #5 clk = ~clk;

    store_buffer_fwd #(.SB_DEPTH(D), .DATA_W(32), .ADDR_W(32), .WAY_NUM(2), .COALESCE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .enq_valid_i(enq_valid_i), .enq_ready_o(enq_ready_o), .enq_addr_i(enq_addr_i),
        .enq_data_i(enq_data_i), .enq_strb_i(enq_strb_i), .enq_uncached_i(enq_uncached_i),
        .enq_hit_i(enq_hit_i), .commit_i(commit_i),
        .deq_valid_o(deq_valid_o), .deq_ready_i(deq_ready_i), .deq_addr_o(deq_addr_o),
        .deq_data_o(deq_data_o), .deq_strb_o(deq_strb_o), .deq_uncached_o(deq_uncached_o),
        .deq_hit_o(deq_hit_o), .ld_addr_i(ld_addr_i), .fwd_data_o(fwd_data_o),
        .fwd_mask_o(fwd_mask_o), .count_o(count_o), .empty_o(empty_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        enq_valid_i = 0; commit_i = 0; deq_ready_i = 0; flush_i = 0;
        enq_uncached_i = 0; enq_hit_i = 2'b00;
    endtask

    task automatic drive_enq(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        enq_valid_i = 1; enq_addr_i = a; enq_data_i = d; enq_strb_i = s;
    endtask

    task automatic do_flush();
        idle(); flush_i = 1; tick(); flush_i = 0; #1;
    endtask

    task automatic test_reset();
        rst_n = 0; idle(); enq_addr_i = 0; enq_data_i = 0; enq_strb_i = 0; ld_addr_i = 0;
        tick(); tick();
        rst_n = 1; #1;
        n_chk++; if (enq_ready_o !== 1'b1) begin n_bad++; $display("FAIL rst_enq_ready got=%b want=1", enq_ready_o); end
        n_chk++; if (deq_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_deq_valid got=%b want=0", deq_valid_o); end
        n_chk++; if (fwd_mask_o !== 4'h0) begin n_bad++; $display("FAIL rst_fwd_mask got=%h want=0", fwd_mask_o); end
        n_chk++; if (fwd_data_o !== 32'h0) begin n_bad++; $display("FAIL rst_fwd_data got=%h want=0", fwd_data_o); end
        n_chk++; if (count_o !== 3'd0) begin n_bad++; $display("FAIL rst_count got=%0d want=0", count_o); end
        n_chk++; if (empty_o !== 1'b1) begin n_bad++; $display("FAIL rst_empty got=%b want=1", empty_o); end
    endtask

    task automatic test_basic();
        idle(); enq_hit_i = 2'b10; drive_enq(32'h1000, 32'hAABBCCDD, 4'hF); #1;
        n_chk++; if (enq_ready_o !== 1'b1) begin n_bad++; $display("FAIL basic_ready got=%b want=1", enq_ready_o); end
        tick();
        idle(); commit_i = 1; ld_addr_i = 32'h1000; #1;
        n_chk++; if (deq_valid_o !== 1'b0) begin n_bad++; $display("FAIL basic_early_deq got=%b want=0", deq_valid_o); end
        n_chk++; if (fwd_data_o !== 32'hAABBCCDD || fwd_mask_o !== 4'hF) begin n_bad++; $display("FAIL basic_fwd got=%h/%h want=aabbccdd/f", fwd_data_o, fwd_mask_o); end
        tick();
        idle(); deq_ready_i = 1; #1;
        n_chk++; if (deq_valid_o !== 1'b1) begin n_bad++; $display("FAIL basic_deq_valid got=%b want=1", deq_valid_o); end
        n_chk++; if (deq_addr_o !== 32'h1000 || deq_data_o !== 32'hAABBCCDD) begin n_bad++; $display("FAIL basic_deq_word got=%h/%h want=1000/aabbccdd", deq_addr_o, deq_data_o); end
        n_chk++; if (deq_hit_o !== 2'b10 || deq_uncached_o !== 1'b0 || deq_strb_o !== 4'hF) begin n_bad++; $display("FAIL basic_deq_attr got=%b/%b/%h want=10/0/f", deq_hit_o, deq_uncached_o, deq_strb_o); end
        tick();
        idle(); #1;
        n_chk++; if (empty_o !== 1'b1 || deq_valid_o !== 1'b0) begin n_bad++; $display("FAIL basic_drained got=%b/%b want=1/0", empty_o, deq_valid_o); end
    endtask

    task automatic test_coalesce();
        idle(); drive_enq(32'h2000, 32'h0000_1122, 4'h3); tick();
        drive_enq(32'h2000, 32'h3344_0000, 4'hC); #1;
        n_chk++; if (enq_ready_o !== 1'b1) begin n_bad++; $display("FAIL coal_ready got=%b want=1", enq_ready_o); end
        tick();
        idle(); ld_addr_i = 32'h2002; #1;
        n_chk++; if (count_o !== 3'd1) begin n_bad++; $display("FAIL coal_count got=%0d want=1", count_o); end
        n_chk++; if (fwd_mask_o !== 4'hF || fwd_data_o !== 32'h3344_1122) begin n_bad++; $display("FAIL coal_fwd got=%h/%h want=33441122/f", fwd_data_o, fwd_mask_o); end
        do_flush();
        n_chk++; if (count_o !== 3'd0) begin n_bad++; $display("FAIL coal_flush got=%0d want=0", count_o); end
    endtask

    task automatic test_full();
        idle();
        for (int i = 0; i < D; i++) begin
            drive_enq(32'h4000 + 32'(i * 16), 32'h1111_1111 * 32'(i + 1), 4'hF); tick();
        end
        drive_enq(32'h4040, 32'h0, 4'hF); #1;
        n_chk++; if (enq_ready_o !== 1'b0) begin n_bad++; $display("FAIL full_ready got=%b want=0", enq_ready_o); end
        n_chk++; if (count_o !== 3'd4) begin n_bad++; $display("FAIL full_count got=%0d want=4", count_o); end
        drive_enq(32'h4030, 32'h0000_00EE, 4'h1); #1;
        n_chk++; if (enq_ready_o !== 1'b1) begin n_bad++; $display("FAIL full_coal_ready got=%b want=1", enq_ready_o); end
        tick();
        idle(); ld_addr_i = 32'h4030; #1;
        n_chk++; if (count_o !== 3'd4) begin n_bad++; $display("FAIL full_coal_count got=%0d want=4", count_o); end
        n_chk++; if (fwd_data_o !== 32'h4444_44EE || fwd_mask_o !== 4'hF) begin n_bad++; $display("FAIL full_coal_fwd got=%h/%h want=444444ee/f", fwd_data_o, fwd_mask_o); end
        commit_i = 1; tick();
        idle(); deq_ready_i = 1; drive_enq(32'h4050, 32'h0, 4'hF); #1;
        n_chk++; if (enq_ready_o !== 1'b0 || deq_valid_o !== 1'b1) begin n_bad++; $display("FAIL full_deq_noslot got=%b/%b want=0/1", enq_ready_o, deq_valid_o); end
        tick();
        idle(); #1;
        n_chk++; if (count_o !== 3'd3) begin n_bad++; $display("FAIL full_after_deq got=%0d want=3", count_o); end
        do_flush();
        n_chk++; if (count_o !== 3'd0 || empty_o !== 1'b1) begin n_bad++; $display("FAIL full_flush got=%0d/%b want=0/1", count_o, empty_o); end
    endtask

    task automatic test_flush();
        idle();
        drive_enq(32'h5000, 32'hA0A0_A0A0, 4'hF); tick();
        drive_enq(32'h5100, 32'hB0B0_B0B0, 4'hF); tick();
        drive_enq(32'h5200, 32'hC0C0_C0C0, 4'hF); tick();
        idle(); commit_i = 1; tick();
        do_flush();
        n_chk++; if (count_o !== 3'd1) begin n_bad++; $display("FAIL flush_count got=%0d want=1", count_o); end
        ld_addr_i = 32'h5100; #1;
        n_chk++; if (fwd_mask_o !== 4'h0) begin n_bad++; $display("FAIL flush_fwd_b got=%h want=0", fwd_mask_o); end
        ld_addr_i = 32'h5200; #1;
        n_chk++; if (fwd_mask_o !== 4'h0) begin n_bad++; $display("FAIL flush_fwd_c got=%h want=0", fwd_mask_o); end
        ld_addr_i = 32'h5000; #1;
        n_chk++; if (fwd_data_o !== 32'hA0A0_A0A0 || fwd_mask_o !== 4'hF) begin n_bad++; $display("FAIL flush_fwd_a got=%h/%h want=a0a0a0a0/f", fwd_data_o, fwd_mask_o); end
        n_chk++; if (deq_valid_o !== 1'b1 || deq_addr_o !== 32'h5000) begin n_bad++; $display("FAIL flush_deq got=%b/%h want=1/5000", deq_valid_o, deq_addr_o); end
        deq_ready_i = 1; tick();
        idle(); #1;
        n_chk++; if (empty_o !== 1'b1) begin n_bad++; $display("FAIL flush_drain got=%b want=1", empty_o); end
    endtask

    task automatic test_fwd_priority();
        idle(); drive_enq(32'h3004, 32'h1111_1111, 4'hF); tick();
        idle(); commit_i = 1; tick();
        idle(); drive_enq(32'h3004, 32'h0000_0022, 4'h1); tick();
        idle(); ld_addr_i = 32'h3004; #1;
        n_chk++; if (count_o !== 3'd2) begin n_bad++; $display("FAIL prio_count got=%0d want=2", count_o); end
        n_chk++; if (fwd_data_o !== 32'h1111_1122 || fwd_mask_o !== 4'hF) begin n_bad++; $display("FAIL prio_fwd got=%h/%h want=11111122/f", fwd_data_o, fwd_mask_o); end
        deq_ready_i = 1; tick();
        idle(); #1;
        n_chk++; if (fwd_data_o !== 32'h0000_0022 || fwd_mask_o !== 4'h1) begin n_bad++; $display("FAIL prio_young_only got=%h/%h want=00000022/1", fwd_data_o, fwd_mask_o); end
        do_flush();
        n_chk++; if (empty_o !== 1'b1) begin n_bad++; $display("FAIL prio_flush got=%b want=1", empty_o); end
    endtask

    task automatic test_uncached();
        idle(); enq_uncached_i = 1; drive_enq(32'h6000, 32'h5555_5555, 4'hF); tick();
        idle(); drive_enq(32'h6000, 32'h0000_7700, 4'h2); tick();
        idle(); ld_addr_i = 32'h6000; #1;
        n_chk++; if (count_o !== 3'd2) begin n_bad++; $display("FAIL unc_no_coal got=%0d want=2", count_o); end
        n_chk++; if (fwd_data_o !== 32'h5555_7755 || fwd_mask_o !== 4'hF) begin n_bad++; $display("FAIL unc_fwd got=%h/%h want=55557755/f", fwd_data_o, fwd_mask_o); end
        commit_i = 1; tick();
        idle(); #1;
        n_chk++; if (deq_valid_o !== 1'b1 || deq_uncached_o !== 1'b1 || deq_addr_o !== 32'h6000) begin n_bad++; $display("FAIL unc_deq got=%b/%b/%h want=1/1/6000", deq_valid_o, deq_uncached_o, deq_addr_o); end
        do_flush();
        deq_ready_i = 1; tick();
        idle(); #1;
        n_chk++; if (empty_o !== 1'b1) begin n_bad++; $display("FAIL unc_drain got=%b want=1", empty_o); end
    endtask

    task automatic test_random_wrap();
        ent_t mq[$];
        ent_t tmp;
        int   ncom = 0;
        int   seq = 0;
        logic exp_ready, dq, en;
        idle(); ld_addr_i = 32'h0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            enq_valid_i    = ($urandom_range(3) != 0);
            enq_addr_i     = 32'h8000 + 32'(seq * 16);
            enq_data_i     = $urandom;
            enq_strb_i     = 4'hF;
            enq_uncached_i = 1'($urandom_range(1));
            commit_i       = (ncom < mq.size()) && ($urandom_range(1) == 1);
            deq_ready_i    = ($urandom_range(1) == 1);
            flush_i        = ($urandom_range(7) == 0);
            #1;
            exp_ready = !flush_i && (mq.size() < D);
            n_chk++; if (enq_ready_o !== exp_ready) begin n_bad++; $display("FAIL rnd_ready cyc=%0d got=%b want=%b", cyc, enq_ready_o, exp_ready); end
            n_chk++; if (int'(count_o) != mq.size()) begin n_bad++; $display("FAIL rnd_count cyc=%0d got=%0d want=%0d", cyc, count_o, mq.size()); end
            n_chk++; if (deq_valid_o !== (ncom > 0)) begin n_bad++; $display("FAIL rnd_deq_valid cyc=%0d got=%b want=%b", cyc, deq_valid_o, ncom > 0); end
            if (ncom > 0) begin
                n_chk++; if (deq_addr_o !== mq[0].a || deq_data_o !== mq[0].d) begin n_bad++; $display("FAIL rnd_order cyc=%0d got=%h/%h want=%h/%h", cyc, deq_addr_o, deq_data_o, mq[0].a, mq[0].d); end
            end
            dq = (ncom > 0) && deq_ready_i;
            en = enq_valid_i && exp_ready;
            if (dq) tmp = mq.pop_front();
            ncom = ncom + int'(commit_i) - int'(dq);
            if (flush_i) while (mq.size() > ncom) tmp = mq.pop_back();
            if (en) begin
                mq.push_back('{enq_addr_i, enq_data_i});
                seq++;
            end
            tick();
        end
        idle(); drive_enq(32'hF000, 32'h1234_5678, 4'hF); tick();
        idle(); commit_i = 1; tick();
        idle(); rst_n = 0; tick();
        rst_n = 1; #1;
        n_chk++; if (empty_o !== 1'b1 || deq_valid_o !== 1'b0) begin n_bad++; $display("FAIL rnd_reset got=%b/%b want=1/0", empty_o, deq_valid_o); end
        n_chk++; if (count_o !== 3'd0) begin n_bad++; $display("FAIL rnd_reset_count got=%0d want=0", count_o); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_coalesce();
        test_full();
        test_flush();
        test_fwd_priority();
        test_uncached();
        test_random_wrap();
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
